gf180mcu_fd_sc_mcu7t5v0__clkdiv_n: RTL and testbench
====================================================

// Module: gf180mcu_fd_sc_mcu7t5v0__clkdiv_n
// PURPOSE
//  Parametrised, glitch-free clock divider. Successor to the clkbuf family:
//  drives Z at CLK/R, where ratio R is programmable at run time.
//  Ratio changes and enable changes take effect only on period boundaries.
//  Z is a flop output, so it never glitches.
//  Used for low-speed peripheral and scan clock generation beside the clkbuf/clkinv cells.
// PARAMETERS
//  DIV_W    4   width of the ratio field; legal R = 2 .. 2**DIV_W-1
//  DEF_DIV  2   ratio loaded at reset; clamped as for DIV
// PORTS
//  CLK   input   1      source clock; all state changes on posedge CLK
//  RST   input   1      asynchronous, active-high reset
//  EN    input   1      run request; level sensitive
//  DIV   input   DIV_W  new ratio; sampled only when LD=1
//  LD    input   1      one-cycle load strobe for DIV
//  BUSY  output  1      new ratio is pending and not yet applied
//  Z     output  1      divided clock (registered)
//  VDD   inout   1      supply
//  VSS   inout   1      ground
// BEHAVIOUR
//  Reset (async, RST=1): Z=0, BUSY=0, cnt=0, state=IDLE, active ratio Ra=clamp(DEF_DIV),
//    pending ratio Rp=Ra. Release is synchronous to CLK; first evaluation at the next posedge.
//  clamp(x): x<2 -> 2, else x. Applies to both DEF_DIV and DIV.
//  States:
//    IDLE: Z=0, cnt=0. EN=1 at posedge -> RUN, cnt=0, Z=1 at that same edge
//      (Z rises 1 edge after EN is sampled).
//    RUN: each posedge cnt = (cnt==Ra-1) ? 0 : cnt+1.
//      Z_next = (cnt_next < ceil(Ra/2)).
//      High phase = ceil(Ra/2) CLK cycles; low phase = floor(Ra/2) CLK cycles.
//      EN=0 sampled -> STOP.
//    STOP: keep counting until the wrap edge (cnt==Ra-1).
//      At the wrap edge: if EN=1 -> RUN (new period, Z=1); else -> IDLE (Z=0, cnt=0).
//      EN re-asserted mid-period cancels the stop; no truncated pulse is produced.
//  Ratio update:
//    LD=1 at posedge: Rp=clamp(DIV), BUSY=1 (visible after the edge).
//    In RUN/STOP at the wrap edge: Ra=Rp, BUSY=0, and the new period uses the new Ra.
//    In IDLE: applied at the next posedge (BUSY high for exactly 1 cycle).
//    LD while BUSY=1: Rp is overwritten; BUSY stays 1; only the last value is applied.
//    LD on the wrap edge itself: the value loaded on that edge is applied at the next wrap,
//      not the current one. BUSY stays 1.
//  Boundaries:
//    Ra=2: Z toggles every cycle.
//    Ra=2**DIV_W-1: cnt must not overflow DIV_W bits.
//    Reset mid-period: Z=0 immediately; the pending ratio is discarded.
//  Arithmetic: cnt is DIV_W bits, unsigned. ceil(Ra/2) = (Ra+1)>>1, computed in DIV_W+1 bits.
// STRUCTURE
//  Package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg holds:
//    state enum {IDLE, RUN, STOP}; MIN_DIV=2; function clamp_div().
//  Sub-module gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt: modulo-Ra counter with a wrap flag.
//  The top level holds the FSM, the Ra/Rp/BUSY registers and the Z flop.
//  VDD/VSS are pass-through only; no functional use.
// TESTING
//  1. DEF_DIV=2, EN=1 after reset -> Z=1,0,1,0... on consecutive edges; BUSY=0 throughout.
//  2. LD with DIV=5 mid-period -> BUSY=1 until the wrap edge; then Z=1 for 3 cycles, 0 for 2, repeating.
//  3. LD DIV=0 and LD DIV=1 -> Ra=2 (clamped); divide-by-2 waveform.
//  4. Ra=7, EN drops at cnt=1 -> Z completes 4 high + 3 low, then stays 0 in IDLE;
//     re-raise EN -> Z=1 one edge later.
//  5. Two LDs while BUSY (DIV=3, then DIV=9) -> only 9 applied; period = 9 cycles (5 high / 4 low).
//  6. RST asserted mid-high-phase -> Z=0 asynchronously; after release + EN, Ra=DEF_DIV.
//     DIV_W=4 with Ra=15: cnt reaches 14 and wraps with no overflow.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg.sv
// Shared types and helpers for the programmable glitch-free clock divider.
package gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int unsigned MIN_DIV = 2;

  // Ratios below 2 cannot produce a high and a low phase, so they are raised to 2.
  function automatic int unsigned clamp_div(input int unsigned x);
    return (x < MIN_DIV) ? MIN_DIV : x;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt.sv
// Modulo-ratio period counter; wrap flags the last cycle of a divided-clock period.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt
  import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIV_W-1:0] ratio,
  output logic [DIV_W-1:0] cnt_next,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt_reg;

  // cnt never exceeds ratio-1, so cnt+1 always fits in DIV_W bits.
  assign wrap = inc && (cnt_reg == ratio - DIV_W'(1));

  always_comb begin
    cnt_next = cnt_reg;
    if (clr)
      cnt_next = '0;
    else if (inc)
      cnt_next = wrap ? '0 : cnt_reg + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_next;
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdiv_n.sv
// Programmable glitch-free clock divider: Z = CLK/Ra, with ratio and enable
// changes deferred to period boundaries.
module gf180mcu_fd_sc_mcu7t5v0__clkdiv_n
  import gf180mcu_fd_sc_mcu7t5v0__clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W   = 4,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LD,
  output logic             BUSY,
  output logic             Z,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam logic [DIV_W-1:0] RA_RST = DIV_W'(clamp_div(DEF_DIV));

  state_t           state_reg;
  logic [DIV_W-1:0] ra_reg;
  logic [DIV_W-1:0] rp_reg;
  logic             busy_reg;
  logic             z_reg;

  logic [DIV_W-1:0] cnt_next;
  logic             wrap;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [DIV_W:0]   half;
  logic             z_next_run;
  logic [DIV_W-1:0] div_clamped;
  logic             apply;

  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  assign cnt_clr     = (state_reg == IDLE);
  assign cnt_inc     = (state_reg != IDLE);
  assign half        = ({1'b0, ra_reg} + (DIV_W+1)'(1)) >> 1;
  assign z_next_run  = ({1'b0, cnt_next} < half);
  assign div_clamped = DIV_W'(clamp_div(32'(DIV)));
  // Ratio swaps happen only where a fresh period starts: every edge while idle, or the wrap edge.
  assign apply       = (state_reg == IDLE) || wrap;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_cnt #(
    .DIV_W (DIV_W)
  ) u_cnt (
    .clk      (CLK),
    .rst      (RST),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .ratio    (ra_reg),
    .cnt_next (cnt_next),
    .wrap     (wrap)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      z_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      ra_reg    <= RA_RST;
      rp_reg    <= RA_RST;
    end else begin
      if (LD)
        rp_reg <= div_clamped;

      // A load landing on the apply edge stays pending for the following boundary.
      if (apply) begin
        ra_reg   <= rp_reg;
        busy_reg <= LD;
      end else begin
        busy_reg <= busy_reg | LD;
      end

      case (state_reg)
        IDLE: begin
          state_reg <= EN ? RUN : IDLE;
          z_reg     <= EN;
        end
        RUN, STOP: begin
          if (wrap && !EN) begin
            state_reg <= IDLE;
            z_reg     <= 1'b0;
          end else begin
            state_reg <= EN ? RUN : STOP;
            z_reg     <= z_next_run;
          end
        end
        default: begin
          state_reg <= IDLE;
          z_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY = busy_reg;
  assign Z    = z_reg;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n.sv
// Directed self-checking bench for the programmable clock divider (DIV_W=4, DEF_DIV=2).
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdiv_n;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] div;
  logic       ld;
  logic       busy;
  logic       z;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  int checks = 0;
  int errors = 0;

  gf180mcu_fd_sc_mcu7t5v0__clkdiv_n #(
    .DIV_W   (4),
    .DEF_DIV (2)
  ) dut (
    .CLK  (clk),
    .RST  (rst),
    .EN   (en),
    .DIV  (div),
    .LD   (ld),
    .BUSY (busy),
    .Z    (z),
    .VDD  (vdd),
    .VSS  (vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One tick per character; zs gives Z after each edge, bs gives BUSY (empty string skips BUSY).
  task automatic expect_seq(input string tag, input string zs, input string bs);
    for (int i = 0; i < zs.len(); i++) begin
      tick();
      $display("%s step %0d: z=%b busy=%b", tag, i, z, busy);
      chk($sformatf("%s z[%0d]", tag, i), z, zs[i] == "1");
      if (bs.len() != 0)
        chk($sformatf("%s busy[%0d]", tag, i), busy, bs[i] == "1");
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    div = 4'd0;
    ld  = 1'b0;

    #7;
    chk("reset z", z, 1'b0);
    chk("reset busy", busy, 1'b0);
    rst = 1'b0;
    expect_seq("idle", "0", "0");

    // Divide by the default ratio 2.
    en = 1'b1;
    expect_seq("div2", "101010", "000000");
    expect_seq("div2b", "1", "0");

    // Load 5 mid-period; applied on the next wrap.
    ld = 1'b1; div = 4'd5;
    expect_seq("ld5", "0", "1");
    ld = 1'b0;
    expect_seq("div5", "1110011100", "0000000000");

    // Load 3 on the wrap edge itself: current wrap keeps 5, next wrap applies 3.
    ld = 1'b1; div = 4'd3;
    expect_seq("ldwrap", "1", "1");
    ld = 1'b0;
    expect_seq("wrap3", "1100110110", "1111000000");
    expect_seq("wrap3b", "1", "0");

    // DIV=0 and DIV=1 both clamp to 2.
    ld = 1'b1; div = 4'd0;
    expect_seq("ld0", "1", "1");
    ld = 1'b0;
    expect_seq("clamp0", "010101", "100000");
    ld = 1'b1; div = 4'd1;
    expect_seq("ld1", "0", "1");
    ld = 1'b0;
    expect_seq("clamp1", "1010", "0000");

    // Ratio 7, then drop EN at cnt=1: finish 4 high + 3 low, then idle.
    expect_seq("pre7", "1", "0");
    ld = 1'b1; div = 4'd7;
    expect_seq("ld7", "0", "1");
    ld = 1'b0;
    expect_seq("start7", "11", "00");
    en = 1'b0;
    expect_seq("stop7", "1100000", "0000000");
    en = 1'b1;
    expect_seq("restart", "1", "0");

    // EN pulse low mid-period is cancelled without truncation.
    expect_seq("cancel_a", "1", "");
    en = 1'b0;
    expect_seq("cancel_b", "1", "");
    en = 1'b1;
    expect_seq("cancel_c", "10001", "");

    // Two loads while busy: only the last (9) is applied.
    ld = 1'b1; div = 4'd3;
    expect_seq("ld3", "1", "1");
    div = 4'd9;
    expect_seq("ld9", "1", "1");
    ld = 1'b0;
    expect_seq("div9", "10001111100001", "11110000000000");

    // Maximum ratio 15: counter runs to 14 and wraps.
    ld = 1'b1; div = 4'd15;
    expect_seq("ld15", "1", "1");
    ld = 1'b0;
    expect_seq("div15", "11100001111111100000001", "11111110000000000000000");

    // Asynchronous reset mid-high-phase with a load pending.
    ld = 1'b1; div = 4'd5;
    expect_seq("ldrst", "1", "1");
    ld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async z", z, 1'b0);
    chk("async busy", busy, 1'b0);
    tick();
    #2;
    rst = 1'b0;
    expect_seq("postrst", "1010", "0000");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
